spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  Synthesizable SPI master: serialises tx_data on mosi, captures miso into rx_data.
//  Replaces bench-only master sequencing for on-chip use. Drives one of NUM_SS active-low selects.
//  Adds generic width, run-time CPOL/CPHA, bit order and a programmable sclk divider.
//  Sits between a local controller (start/busy/done) and external SPI slaves such as main.
// PARAMETERS
//  WIDTH     8  bits per transfer (>=2)
//  CLK_DIV   2  clk cycles per sclk half-period (>=1)
//  NUM_SS    4  number of slave-select outputs (>=1)
//  SS_IDX_W  2  width of ss_idx; NUM_SS <= 2**SS_IDX_W
//  LSB_FIRST 0  0: MSB first (bit WIDTH-1 first); 1: LSB first
// PORTS
//  clk      in   1         system clock, all logic on posedge
//  rst_l    in   1         asynchronous, active-low reset
//  start    in   1         request transfer; honoured only when busy=0
//  tx_data  in   WIDTH     word to send, captured on accept
//  mode     in   2         {CPOL,CPHA}, captured on accept
//  ss_idx   in   SS_IDX_W  slave to select, captured on accept
//  busy     out  1         transfer in progress
//  done     out  1         one-cycle pulse: transfer complete, rx_data valid
//  rx_data  out  WIDTH     last received word, held until next done
//  sclk     out  1         SPI clock
//  mosi     out  1         master out
//  miso     in   1         master in
//  ss_l     out  NUM_SS    active-low selects, at most one low
// BEHAVIOUR
//  Reset (async, immediate, any state): state=IDLE, busy=0, done=0, rx_data=0,
//    sclk=0, mosi=0, ss_l=all 1, mode reg=0, bit/div counters=0.
//  States: IDLE -> LOAD -> SETUP -> SHIFT -> HOLD -> IDLE. All outputs registered.
//  IDLE: start=1 and ss_idx<NUM_SS at edge E0 -> latch tx_data/mode/ss_idx, go LOAD, busy=1.
//    start with ss_idx>=NUM_SS is ignored; no busy, no done. start ignored while busy=1.
//  LOAD (1 cycle): sclk<=CPOL; ss_l stays high, so CPOL change never glitches a selected slave.
//  E1 = E0+1: ss_l[idx]=0; CPHA=0: mosi=first bit. Divider counts CLK_DIV cycles per half-period.
//  sclk toggles at E1+k*CLK_DIV, k=1..2*WIDTH. Edge 2j-1 is leading, edge 2j is trailing (j=1..WIDTH).
//  CPHA=0: sample miso on leading edges. Drive the next bit on trailing edges 2..2W-2.
//  CPHA=1: drive the bit on leading edges. Sample miso on trailing edges.
//  Sample and drive happen in the same clk edge as the sclk toggle.
//  Slaves see mosi stable for >=CLK_DIV cycles around each sampling edge.
//  HOLD: after edge 2W, sclk=CPOL for CLK_DIV cycles. Then at E1+(2W+1)*CLK_DIV:
//    ss_l all high, mosi=0, busy=0, done=1 for one cycle, rx_data=shift reg, state IDLE.
//  Latency start-accept to done = 1+(2*WIDTH+1)*CLK_DIV cycles (WIDTH=8, CLK_DIV=2: 35).
//  Back-to-back: start sampled while done=1 is accepted. ss_l high >=2 cycles between transfers.
//  rx bits are placed in the same order as sent: MSB-first fills bit WIDTH-1 first.
//  Reset mid-transfer: selects released and sclk=0 at once, rx_data=0, no done pulse.
//  Divider and bit counters never wrap mid-transfer. CLK_DIV=1 gives sclk=clk/2.
// TESTING
//  1. WIDTH=8, CLK_DIV=2, mode=00, tx=8'h4f, ss_idx=0, slave model returns 8'hb7
//     -> mosi 0,1,0,0,1,1,1,1 at sclk rising edges; rx_data=8'hb7; done 35 cycles after accept.
//  2. mode=11, tx=8'ha5, slave echoes previous byte 8'h3c -> sclk idles 1.
//     mosi changes on falling edges and is sampled on rising edges; rx_data=8'h3c.
//     No sclk edge occurs while ss_l[idx]=0 during LOAD.
//  3. LSB_FIRST=1, WIDTH=12, tx=12'h801 -> first mosi bit 1, then ten 0s, last 1.
//     Slave sends 12'h0f0 -> rx_data=12'h0f0.
//  4. start pulsed again mid-transfer with tx=8'hff; ss_idx=7 with NUM_SS=4
//     -> both ignored; current transfer unchanged; only one done.
//  5. rst_l low at sclk edge 5 -> ss_l=4'hf, sclk=0, busy=0, rx_data=0 immediately.
//     After release, a new start completes normally.
//  6. Back-to-back: start held high, ss_idx 1 then 2 -> ss_l[1] then ss_l[2] low.
//     >=2 cycles all-high between them; two done pulses.

Source files
------------

// File: rtl/spi_master.sv
// SPI master with run-time CPOL/CPHA, build-time width, bit order and sclk divider.
// A start/busy/done handshake on the local side drives one of NUM_SS active-low selects.
module spi_master #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_SS    = 4,
  parameter int SS_IDX_W  = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                start,
  input  logic [WIDTH-1:0]    tx_data,
  input  logic [1:0]          mode,
  input  logic [SS_IDX_W-1:0] ss_idx,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    rx_data,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_SS-1:0]   ss_l
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ss_l_q, ss_l_d;
  logic [1:0]          mode_q, mode_d;
  logic [SS_IDX_W-1:0] ss_q, ss_d;
  logic [WIDTH-1:0]    tx_q, tx_d;
  logic [WIDTH-1:0]    rx_q, rx_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;

  logic              idx_ok, tick, last_edge, sample, tx_bit;
  logic [DIV_W-1:0]  div_next;
  logic [WIDTH-1:0]  tx_shifted, rx_shifted;
  logic [NUM_SS-1:0] sel_mask;

  assign idx_ok    = ({1'b0, ss_idx} < (SS_IDX_W + 1)'(NUM_SS));
  assign sel_mask  = ~(NUM_SS'(1) << ss_q);
  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_next  = tick ? '0 : div_q + DIV_W'(1);
  assign last_edge = (edge_q == EDGE_W'(2 * WIDTH - 1));
  // edge_q even means the upcoming toggle is a leading edge; CPHA picks which edge samples.
  assign sample    = ~edge_q[0] ^ mode_q[0];
  assign tx_bit    = LSB_FIRST ? tx_q[0] : tx_q[WIDTH-1];

  if (LSB_FIRST != 0) begin : g_lsb
    assign tx_shifted = {1'b0, tx_q[WIDTH-1:1]};
    assign rx_shifted = {miso, rx_q[WIDTH-1:1]};
  end else begin : g_msb
    assign tx_shifted = {tx_q[WIDTH-2:0], 1'b0};
    assign rx_shifted = {rx_q[WIDTH-2:0], miso};
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_l_d    = ss_l_q;
    mode_d    = mode_q;
    ss_d      = ss_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_d     = div_q;
    edge_d    = edge_q;
    case (state_q)
      S_IDLE: begin
        if (start && idx_ok) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          tx_d    = tx_data;
          mode_d  = mode;
          ss_d    = ss_idx;
          sclk_d  = mode[1];
        end
      end
      S_LOAD: begin
        // sclk already sits at CPOL while every select is still high.
        state_d = S_SETUP;
        sclk_d  = mode_q[1];
        ss_l_d  = sel_mask;
        div_d   = '0;
        edge_d  = '0;
        if (!mode_q[0]) begin
          mosi_d = tx_bit;
          tx_d   = tx_shifted;
        end
      end
      S_SETUP, S_SHIFT: begin
        div_d = div_next;
        if (tick) begin
          state_d = last_edge ? S_HOLD : S_SHIFT;
          sclk_d  = ~sclk_q;
          edge_d  = edge_q + EDGE_W'(1);
          if (sample) begin
            rx_d = rx_shifted;
          end else if (!last_edge) begin
            mosi_d = tx_bit;
            tx_d   = tx_shifted;
          end
        end
      end
      S_HOLD: begin
        div_d = div_next;
        if (tick) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ss_l_d    = '1;
          mosi_d    = 1'b0;
          rx_data_d = rx_q;
          div_d     = '0;
          edge_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_l_q    <= '1;
      mode_q    <= '0;
      ss_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      div_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_l_q    <= ss_l_d;
      mode_q    <= mode_d;
      ss_q      <= ss_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_l    = ss_l_q;

endmodule
